// File: rtl/pe_array_cfg_loader_pkg.sv
// Shared types and constants for the PE array configuration loader.
// CFG_PARITY_EN adds the ERR state used for parity failures.
package pe_array_cfg_loader_pkg;

  localparam int unsigned ROW_W         = 2;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned SLOT_W        = ROW_W + SEL_W;
  localparam int unsigned N_ROW_FIXED   = 4;
  localparam int unsigned N_SEL_DEFAULT = 4;
  localparam int unsigned N_SLOTS       = N_ROW_FIXED * N_SEL_DEFAULT;
  localparam int unsigned NOP_WORD      = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3
`ifdef CFG_PARITY_EN
    ,
    S_ERR  = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/pe_array_cfg_loader_slot_counter.sv
// Row-major {row, sel} slot cursor; wrap flags the step out of the last slot.
module pe_slot_counter
  import pe_array_cfg_loader_pkg::*;
#(
  parameter int unsigned N_SEL = N_SEL_DEFAULT,
  parameter int unsigned N_ROW = N_ROW_FIXED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [ROW_W-1:0] row,
  output logic [SEL_W-1:0] sel,
  output logic             wrap
);

  logic last_sel;
  logic last_row;

  assign last_sel = (sel == SEL_W'(N_SEL - 1));
  assign last_row = (row == ROW_W'(N_ROW - 1));
  assign wrap     = en && last_sel && last_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      sel <= '0;
    end else if (clr) begin
      row <= '0;
      sel <= '0;
    end else if (en) begin
      if (last_sel) begin
        sel <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        sel <= sel + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_array_cfg_loader.sv
// Loads N_ROW*N_SEL config words into the PE array, then steps every slot for run_iters passes.
// Define CFG_PARITY_EN for an even-parity MSB on cfg_data with a sticky error state.
module pe_array_cfg_loader
  import pe_array_cfg_loader_pkg::*;
#(
  parameter int unsigned INST_W = 32,
  parameter int unsigned N_SEL  = N_SEL_DEFAULT,
  parameter int unsigned N_ROW  = N_ROW_FIXED,
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] run_iters,
  input  logic              cfg_valid,
`ifdef CFG_PARITY_EN
  input  logic [INST_W:0]   cfg_data,
`else
  input  logic [INST_W-1:0] cfg_data,
`endif
  output logic              cfg_ready,
  output logic [INST_W-1:0] pe_config,
  output logic              init_vld,
  output logic [SLOT_W-1:0] init_PE_array,
  output logic [SLOT_W-1:0] run_PE_array,
  output logic              run_vld,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e             state;
  logic [ITER_W-1:0]  iters;
  logic [ITER_W-1:0]  pass;
  logic [ITER_W-1:0]  pass_nxt;
  logic [ITER_W-1:0]  iters_eff;
  logic               xfer;
  logic               par_ok;
  logic               accept;
  logic               cur_clr;
  logic               run_en;
  logic [ROW_W-1:0]   load_row;
  logic [SEL_W-1:0]   load_sel;
  logic               load_wrap;
  logic [ROW_W-1:0]   run_row;
  logic [SEL_W-1:0]   run_sel;
  logic               run_wrap;

  // cfg_ready is only ever high in LOAD, so it doubles as the state qualifier.
  assign xfer = cfg_valid && cfg_ready;
`ifdef CFG_PARITY_EN
  assign par_ok = ~^cfg_data;
`else
  assign par_ok = 1'b1;
  assign err    = 1'b0;
`endif
  assign accept    = xfer && par_ok;
  assign cur_clr   = (state == S_IDLE) && start;
  assign run_en    = (state == S_RUN);
  assign pass_nxt  = pass + 1'b1;
  assign iters_eff = (iters == '0) ? ITER_W'(1) : iters;

  pe_slot_counter #(.N_SEL(N_SEL), .N_ROW(N_ROW)) u_load_cur (
    .clk (clk), .rst (rst), .en (accept), .clr (cur_clr),
    .row (load_row), .sel (load_sel), .wrap (load_wrap)
  );

  // The run cursor ends every sequence wrapped to slot 0, so it reads 0 outside RUN.
  pe_slot_counter #(.N_SEL(N_SEL), .N_ROW(N_ROW)) u_run_cur (
    .clk (clk), .rst (rst), .en (run_en), .clr (cur_clr),
    .row (run_row), .sel (run_sel), .wrap (run_wrap)
  );

  assign run_PE_array = {run_row, run_sel};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      iters         <= '0;
      pass          <= '0;
      cfg_ready     <= 1'b0;
      pe_config     <= '0;
      init_vld      <= 1'b0;
      init_PE_array <= '0;
      run_vld       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef CFG_PARITY_EN
      err           <= 1'b0;
`endif
    end else begin
      init_vld  <= 1'b0;
      pe_config <= INST_W'(NOP_WORD);
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            iters     <= run_iters;
            pass      <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            pe_config     <= cfg_data[INST_W-1:0];
            init_PE_array <= {load_row, load_sel};
            init_vld      <= 1'b1;
            if (load_wrap) begin
              cfg_ready <= 1'b0;
              run_vld   <= 1'b1;
              state     <= S_RUN;
            end
          end
`ifdef CFG_PARITY_EN
          else if (xfer) begin
            cfg_ready <= 1'b0;
            err       <= 1'b1;
            state     <= S_ERR;
          end
`endif
        end
        S_RUN: begin
          if (run_wrap) begin
            pass <= pass_nxt;
            if (pass_nxt == iters_eff) begin
              run_vld <= 1'b0;
              done    <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: doc/pe_array_cfg_loader.md
Name: pe_array_cfg_loader

Overview:
Upstream control stage for the 4-row PE array. Accepts a stream of PE/LSU configuration words and broadcasts them on pe_config, with a matching init_PE_array slot code per word. After all slots are loaded, it steps run_PE_array through every slot for a programmed number of passes, then pulses done. Sits between the host/config DMA and the PE array.

Parameters:
INST_W, 32, width of one configuration word; equals the array's PE instruction width.
N_SEL, 4, slots per row (sel 0 = LSU, 1..3 = PE0..PE2); legal range 1..8.
N_ROW, 4, rows in the array; fixed by the 2-bit row select.
ITER_W, 16, width of the run pass counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; sampled only in IDLE
run_iters  in  ITER_W  number of run passes; sampled on accepted start
cfg_valid  in  1  config word valid
cfg_data  in  INST_W  config word (INST_W+1 when CFG_PARITY_EN is defined; MSB is even parity)
cfg_ready  out  1  loader accepts a word this cycle
pe_config  out  INST_W  registered config word to the array
init_vld  out  1  pe_config/init_PE_array carry a live word this cycle
init_PE_array  out  5  {row_sel[1:0], sel[2:0]} target slot of the current word
run_PE_array  out  5  {row_sel[1:0], sel[2:0]} slot stepped this cycle
run_vld  out  1  run_PE_array is live
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse at run completion
err  out  1  sticky parity error (0 when CFG_PARITY_EN is undefined)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; slot counter 0; pass counter 0; err 0.
- FSM states: IDLE, LOAD, RUN, DONE (plus ERR when CFG_PARITY_EN is defined).
- IDLE: cfg_ready=0. start=1 latches run_iters and moves to LOAD. start outside IDLE is ignored.
- LOAD: cfg_ready=1. A transfer occurs when cfg_valid && cfg_ready.
  - On the edge of a transfer, register pe_config=cfg_data, init_PE_array={row,sel}, init_vld=1. Latency is 1 cycle, and back-to-back transfers are sustained at 1 word per cycle.
  - With no transfer, init_vld=0 and pe_config=0 (0 is the NOP encoding). init_PE_array holds its last value.
  - Slot order is row-major: row 0 sel 0..N_SEL-1, then row 1, and so on.
  - On the transfer of slot N_ROW*N_SEL-1: cfg_ready drops next cycle and the FSM moves to RUN. The last init_vld pulse overlaps the first RUN cycle.
- RUN: run_vld=1; run_PE_array steps one slot per cycle in the same row-major order.
  - Wrap from the last slot to slot 0 increments the pass counter.
  - When a wrap makes the counter equal to the latched run_iters, go to DONE.
  - run_iters=0 is treated as 1 pass.
- DONE: done=1 for exactly one cycle; run_vld=0; return to IDLE.
- busy=1 in LOAD, RUN, DONE and ERR.
- Upstream holding cfg_valid=0 stalls LOAD indefinitely, with no timeout.
- A reset asserted mid-LOAD or mid-RUN aborts immediately to the reset values. Partially loaded slots are not flushed.

Optional Feature:
CFG_PARITY_EN
- Defined: cfg_data is INST_W+1 bits and its MSB is even parity over the word. On a mismatching transfer:
  - the word is not forwarded (init_vld stays 0);
  - err is set and stays set until reset;
  - the FSM enters ERR and holds there, with cfg_ready=0 and busy=1.
- Undefined: cfg_data is INST_W bits, err is tied to 0, and the ERR state is absent.

Decomposition:
- Shared package/header: state encoding localparams, the slot-code field layout ({row_sel, sel} widths), the NOP config value, and the total slot count N_ROW*N_SEL.
- One sub-module is natural: pe_slot_counter, a row/sel counter with a wrap flag.
  - Instantiated twice: load cursor and run cursor.
  - Ports: clk, rst, en, clr, row, sel, wrap.

Test Plan:
- Reset then start with run_iters=2, 16 back-to-back words 0x100..0x10F: init_vld for 16 consecutive cycles, init_PE_array 0x00,0x01,0x02,0x03,0x08,...,0x1B; pe_config matches with 1-cycle latency; RUN lasts 32 cycles; done pulses once; busy falls the cycle after done.
- Same load with cfg_valid toggling every other cycle: init_vld only on transfer cycles, pe_config=0 in gaps, slot order unchanged, RUN entered after the 16th transfer.
- run_iters=0 and run_iters=1: both give exactly 16 run_vld cycles and one done pulse.
- start pulsed during LOAD and during RUN: ignored, with no counter restart; a second start in IDLE after done runs a full new sequence.
- rst asserted on the 7th word of LOAD: asynchronous clear with all outputs 0 the same cycle; a subsequent start loads from slot 0x00.
- CFG_PARITY_EN: a bad parity on word 5 gives no init_vld for that word, err=1, cfg_ready=0, FSM stuck in ERR until rst, and no done.
